bit_serial_alu: RTL

BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

---
 rtl/bit_serial_alu.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: processes one operand bit per cycle, LSB first, through a 1-bit slice.
// Supports add, and, compare and xor. The chain bit is reported as flag when the operation completes.
module bit_serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       aluctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             flag_q, flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic ai, bi, d_bit, e_bit;

  // One-bit slice: d is the result bit, e is the next chain bit.
  always_comb begin
    ai    = a_q[cnt_q];
    bi    = b_q[cnt_q];
    d_bit = 1'b0;
    e_bit = 1'b0;
    case (op_q)
      2'b00: begin
        d_bit = ai ^ bi ^ c_q;
        e_bit = (ai & bi) | (ai & c_q) | (bi & c_q);
      end
      2'b01: d_bit = ai & bi;
      2'b10: e_bit = (ai & ~bi) | (~(ai ^ bi) & c_q);
      default: d_bit = ai ^ bi;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flag_d  = flag_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = aluctr;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = {d_bit, res_q[WIDTH-1:1]};
        c_d   = e_bit;
        // The counter stops at the last bit so it never wraps for power-of-two widths.
        if (cnt_q == LAST) begin
          flag_d  = e_bit;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign flag   = flag_q;

endmodule
